vga_code_feeder: RTL and testbench

Upstream stage of the 800x600 VGA display. It accepts output words from the CPU over a valid/ready handshake and buffers them in a small FIFO. Each word is mapped through a 16-colour palette into the display's 24-bit `code` (left-half RGB444, right-half RGB444). Each code is held for a programmable number of frames, and updates happen only at frame boundaries, detected from the display's `vsync`.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/vga_code_feeder.sv | 102 ++++++++++
 tb/tb_vga_code_feeder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA code feeder: output width, FSM states and
// the 16-entry RGB444 palette that maps CPU nibbles onto screen colours.
package vga_pkg;

  localparam int CODE_W  = 24;
  localparam int COLOR_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } feeder_state_e;

  localparam logic [COLOR_W-1:0] PALETTE [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
    12'h888, 12'h800, 12'h080, 12'h008,
    12'hF80, 12'h8F0, 12'h08F, 12'h444
  };

  // Map one byte (left nibble, right nibble) onto the two-half display code.
  function automatic logic [CODE_W-1:0] mapWord(input logic [7:0] word);
    return {PALETTE[word[7:4]], PALETTE[word[3:0]]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with first-word-fall-through read data. Pointers
// carry one extra wrap bit so full and empty are told apart without a counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Advance the write and read pointers; a simultaneous push and pop both happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rdPtr_q[AW-1:0]];
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                 (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

endmodule

// File: rtl/vga_code_feeder.sv
// Buffers CPU output words and presents each one as a palette-mapped 24-bit
// display code, changing only on vsync falling edges and holding every word
// for HOLD_FRAMES frames.
module vga_code_feeder
  import vga_pkg::*;
#(
  parameter int HOLD_FRAMES = 36,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              vsync,
  output logic [CODE_W-1:0] code,
  output logic              busy
);

  localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_FRAMES - 1);

  feeder_state_e      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_d;
  logic               vsync_q;
  logic               tick;
  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [7:0]         fifoHead;
  logic               unusedHighBits;

  // Only the low byte carries palette indices.
  assign unusedHighBits = ^in_data[15:8];

  // Ready depends on registered occupancy only, never on a same-cycle pop.
  assign in_ready = !fifoFull && !rst;
  assign fifoPush = in_valid && in_ready;

  // A pop happens exactly when the FSM loads a new word on a frame tick.
  assign fifoPop = tick && !fifoEmpty && ((state_q == IDLE) || (cnt_q == '0));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .wdata (in_data[7:0]),
    .rdata (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Remember last vsync so its falling edge can be turned into a one-cycle tick.
  always_ff @(posedge clk) begin
    if (rst) vsync_q <= 1'b1;
    else     vsync_q <= vsync;
  end

  assign tick   = vsync_q && !vsync;
  assign code_d = mapWord(fifoHead);

  // Frame-hold FSM: load a word on a tick, count down frames, then reload or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            code_q  <= code_d;
            cnt_q   <= HOLD_RELOAD;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!fifoEmpty) begin
            code_q <= code_d;
            cnt_q  <= HOLD_RELOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code = code_q;
  assign busy = (state_q == SHOW) || !fifoEmpty;

endmodule

// File: tb/tb_vga_code_feeder.sv
// Randomised and directed bench for vga_code_feeder. Accepted words are queued
// as expected display codes; a monitor pops them on frame ticks using a
// frame-count view of the hold rule and compares code, busy and in_ready.
module tb_vga_code_feeder;

  localparam int HOLD  = 2;
  localparam int DEPTH = 4;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        inValid  = 1'b0;
  logic [15:0] inData   = 16'h0000;
  logic        vsync    = 1'b1;
  logic        inReady;
  logic [23:0] code;
  logic        busy;

  vga_code_feeder #(
    .HOLD_FRAMES (HOLD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (inData),
    .in_valid (inValid),
    .in_ready (inReady),
    .vsync    (vsync),
    .code     (code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] REF_PALETTE [16] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
    12'h888, 12'h800, 12'h080, 12'h008, 12'hF80, 12'h8F0, 12'h08F, 12'h444
  };

  logic [23:0] wordQ [$];
  int          totalChecks = 0;
  int          badChecks   = 0;
  bit          monitorOn   = 1'b0;
  bit          readyExp    = 1'b0;
  logic [23:0] expCode     = 24'h0;
  bit          lastVsync   = 1'b1;
  int          tickCount   = 0;
  int          lastPopTick = 0;
  bit          haveShown   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model across
  // the coming edge (frame ticks pop the oldest word once the hold has elapsed).
  always @(negedge clk) begin : monitorProc
    bit showing;
    showing = haveShown && ((tickCount - lastPopTick) < HOLD);
    if (monitorOn) begin
      checkOutput("code", 32'(code), 32'(expCode));
      checkOutput("busy", 32'(busy), 32'((wordQ.size() != 0) || showing));
      checkOutput("in_ready", 32'(inReady), 32'(!rst && (wordQ.size() < DEPTH)));
    end
    readyExp = !rst && (wordQ.size() < DEPTH);
    if (rst) begin
      wordQ.delete();
      expCode     = 24'h0;
      lastVsync   = 1'b1;
      haveShown   = 1'b0;
      tickCount   = 0;
      lastPopTick = 0;
    end else begin
      if (lastVsync && !vsync) begin
        tickCount++;
        if (wordQ.size() != 0 && (!haveShown || (tickCount - lastPopTick) >= HOLD)) begin
          expCode     = wordQ.pop_front();
          lastPopTick = tickCount;
          haveShown   = 1'b1;
        end
      end
      lastVsync = vsync;
    end
  end

  // Collector: every accepted word becomes an expected code at the queue tail,
  // added after the monitor so a same-edge push is invisible to that tick.
  always @(negedge clk) begin
    #1;
    if (inValid && readyExp)
      wordQ.push_back({REF_PALETTE[inData[7:4]], REF_PALETTE[inData[3:0]]});
  end

  // Drive one clock cycle worth of inputs.
  task automatic applyStimulus(input logic v, input logic [15:0] d,
                               input logic vs, input logic r);
    inValid = v;
    inData  = d;
    vsync   = vs;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  // Generate frames with vsync high then low, pushing random words at pushPct.
  task automatic runFrames(input int n, input int highLen, input int lowLen,
                           input int pushPct);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < highLen + lowLen; c++) begin
        applyStimulus(($urandom_range(99) < pushPct) ? 1'b1 : 1'b0,
                      16'($urandom()), (c < highLen) ? 1'b1 : 1'b0, 1'b0);
      end
    end
  endtask

  // Directed scenarios first, then a long randomised run.
  initial begin
    rst = 1'b1; inValid = 1'b1; inData = 16'h00AA; vsync = 1'b1;
    @(posedge clk);
    #1;
    monitorOn = 1'b1;
    repeat (2) applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    applyStimulus(1'b1, 16'h0012, 1'b1, 1'b0);
    runFrames(4, 6, 2, 0);

    applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0023, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0045, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0067, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0089, 1'b1, 1'b0);
    runFrames(12, 5, 2, 0);

    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0077, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    runFrames(4, 5, 2, 0);

    applyStimulus(1'b1, 16'h009A, 1'b1, 1'b0);
    runFrames(1, 4, 2, 0);
    applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    runFrames(3, 5, 2, 0);

    applyStimulus(1'b1, 16'h003C, 1'b1, 1'b0);
    runFrames(1, 4, 2, 0);
    repeat (30) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    runFrames(3, 5, 2, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(39) == 0) begin
        applyStimulus(1'b1, 16'($urandom()), 1'b1, 1'b1);
      end else if ($urandom_range(29) == 0) begin
        repeat ($urandom_range(20, 5))
          applyStimulus(1'($urandom_range(1)), 16'($urandom()), 1'b0, 1'b0);
      end else begin
        runFrames(1, $urandom_range(10, 2), $urandom_range(3, 1), 40);
      end
    end

    repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
